regfile_sb: RTL and testbench

- Parametrised successor to the core's 2R/1W register file.
- Generalised in data width, register count and number of read ports.
- Adds same-cycle write-to-read bypass, an optional hardwired zero register, asynchronous clear, and a per-register busy scoreboard.
- Sits between decode (read plus reserve) and writeback (write) in the pipelined core; gives the hazard unit both operand values and operand-ready status.

---
 rtl/regfile_sb.sv | 88 ++++++++
 tb/tb_regfile_sb.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Parametrised register file with write-to-read bypass, optional hardwired zero
// register, and a per-register busy scoreboard for the hazard unit.
`timescale 1ns/1ps
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   r_reg,
  output logic [NRD*XLEN-1:0] r_dat,
  output logic [NRD-1:0]      r_busy,
  input  logic [AW-1:0]       w_reg,
  input  logic [XLEN-1:0]     w_dat,
  input  logic                write,
  input  logic [AW-1:0]       rsv_reg,
  input  logic                rsv,
  output logic                rsv_ok,
  output logic [AW:0]         busy_cnt
);

  logic [XLEN-1:0]  r_mem [NREGS];
  logic [NREGS-1:0] r_busyBits;
  logic [AW:0]      r_busyCnt;

  logic w_wrEn;
  logic w_rsvZero;
  logic w_rsvSet;
  logic w_sameReg;
  logic w_inc;
  logic w_dec;

  assign w_wrEn    = write && !((ZERO_REG != 0) && (w_reg == '0));
  assign w_rsvZero = (ZERO_REG != 0) && (rsv_reg == '0);

  // A writeback landing this cycle frees the register, so a reserve against it is accepted.
  assign rsv_ok    = !rst && rsv &&
                     (w_rsvZero || !r_busyBits[rsv_reg] || (write && (w_reg == rsv_reg)));
  assign w_rsvSet  = rsv_ok && !w_rsvZero;
  assign w_sameReg = w_rsvSet && w_wrEn && (w_reg == rsv_reg);
  assign w_inc     = w_rsvSet && !r_busyBits[rsv_reg];
  assign w_dec     = w_wrEn && r_busyBits[w_reg] && !w_sameReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (w_wrEn) begin
      r_mem[w_reg] <= w_dat;
    end
  end

  // The reserve is applied after the writeback clear so a new producer wins on the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busyBits <= '0;
    end else begin
      if (w_wrEn)   r_busyBits[w_reg]   <= 1'b0;
      if (w_rsvSet) r_busyBits[rsv_reg] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busyCnt <= '0;
    end else begin
      r_busyCnt <= r_busyCnt + {{AW{1'b0}}, w_inc} - {{AW{1'b0}}, w_dec};
    end
  end

  assign busy_cnt = r_busyCnt;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] w_addr;
    logic          w_hit;
    logic          w_zero;

    assign w_addr = r_reg[k*AW +: AW];
    assign w_hit  = w_wrEn && (w_reg == w_addr);
    assign w_zero = (ZERO_REG != 0) && (w_addr == '0);

    assign r_dat[k*XLEN +: XLEN] = (rst || w_zero) ? '0 : (w_hit ? w_dat : r_mem[w_addr]);
    assign r_busy[k]             = !rst && !w_zero && r_busyBits[w_addr] && !w_hit;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: default instance (A) and a 64-bit/16-reg/3-port
// instance without a zero register (B).
`timescale 1ns/1ps
module tb_regfile_sb;

  localparam int K_DAT  = 0;
  localparam int K_BUSY = 1;
  localparam int K_OK   = 2;
  localparam int K_CNT  = 3;

  typedef struct packed {
    logic [1:0]  dut;
    logic [1:0]  kind;
    logic [1:0]  port;
    logic [63:0] val;
  } expItem_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [9:0]   aRReg = '0;
  logic [63:0]  aRDat;
  logic [1:0]   aRBusy;
  logic [4:0]   aWReg = '0;
  logic [31:0]  aWDat = '0;
  logic         aWrite = 1'b0;
  logic [4:0]   aRsvReg = '0;
  logic         aRsv = 1'b0;
  logic         aRsvOk;
  logic [5:0]   aBusyCnt;

  logic [11:0]  bRReg = '0;
  logic [191:0] bRDat;
  logic [2:0]   bRBusy;
  logic [3:0]   bWReg = '0;
  logic [63:0]  bWDat = '0;
  logic         bWrite = 1'b0;
  logic [3:0]   bRsvReg = '0;
  logic         bRsv = 1'b0;
  logic         bRsvOk;
  logic [4:0]   bBusyCnt;

  expItem_t expQ[$];
  string    nameQ[$];
  int       testsRun = 0;
  int       testsFailed = 0;

  regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1)) dutA (
    .clk(clk), .rst(rst), .r_reg(aRReg), .r_dat(aRDat), .r_busy(aRBusy),
    .w_reg(aWReg), .w_dat(aWDat), .write(aWrite), .rsv_reg(aRsvReg), .rsv(aRsv),
    .rsv_ok(aRsvOk), .busy_cnt(aBusyCnt)
  );

  regfile_sb #(.XLEN(64), .NREGS(16), .NRD(3), .ZERO_REG(0)) dutB (
    .clk(clk), .rst(rst), .r_reg(bRReg), .r_dat(bRDat), .r_busy(bRBusy),
    .w_reg(bWReg), .w_dat(bWDat), .write(bWrite), .rsv_reg(bRsvReg), .rsv(bRsv),
    .rsv_ok(bRsvOk), .busy_cnt(bBusyCnt)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] actualOf(input expItem_t it);
    logic [63:0] v;
    v = '0;
    if (it.dut == 2'd0) begin
      case (int'(it.kind))
        K_DAT:   v = {32'h0, aRDat[int'(it.port)*32 +: 32]};
        K_BUSY:  v = {63'h0, aRBusy[it.port[0]]};
        K_OK:    v = {63'h0, aRsvOk};
        default: v = {58'h0, aBusyCnt};
      endcase
    end else begin
      case (int'(it.kind))
        K_DAT:   v = bRDat[int'(it.port)*64 +: 64];
        K_BUSY:  v = {63'h0, bRBusy[it.port]};
        K_OK:    v = {63'h0, bRsvOk};
        default: v = {59'h0, bBusyCnt};
      endcase
    end
    return v;
  endfunction

  task automatic checkOutput(input expItem_t it, input string name);
    logic [63:0] act;
    act = actualOf(it);
    testsRun++;
    if (act !== it.val) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, it.val);
    end
  endtask

  // Inputs settle 1ns after the rising edge; every queued expectation is judged on the falling edge.
  always @(negedge clk) begin
    while (expQ.size() > 0) begin
      checkOutput(expQ.pop_front(), nameQ.pop_front());
    end
  end

  task automatic pushExp(input int dut, input int kind, input int port,
                         input logic [63:0] val, input string name);
    expItem_t it;
    it.dut  = 2'(dut);
    it.kind = 2'(kind);
    it.port = 2'(port);
    it.val  = val;
    expQ.push_back(it);
    nameQ.push_back(name);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
    aWrite = 1'b0;
    aRsv   = 1'b0;
    bWrite = 1'b0;
    bRsv   = 1'b0;
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                               input logic rs, input logic [4:0] rr,
                               input logic [4:0] a0, input logic [4:0] a1);
    nextCycle();
    aWrite  = we;
    aWReg   = wr;
    aWDat   = wd;
    aRsv    = rs;
    aRsvReg = rr;
    aRReg   = {a1, a0};
  endtask

  task automatic applyStimulusB(input logic we, input logic [3:0] wr, input logic [63:0] wd,
                                input logic rs, input logic [3:0] rr,
                                input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
    nextCycle();
    bWrite  = we;
    bWReg   = wr;
    bWDat   = wd;
    bRsv    = rs;
    bRsvReg = rr;
    bRReg   = {a2, a1, a0};
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    pushExp(0, K_DAT, 0, 64'h0, "resetDat");
    pushExp(0, K_CNT, 0, 64'h0, "resetCnt");
    nextCycle();
    rst = 1'b0;

    // Asynchronous reset clears stored data and reservations
    applyStimulus(1, 5, 32'hDEADBEEF, 1, 7, 5, 7);
    pushExp(0, K_DAT, 0, 64'hDEADBEEF, "rstPreBypass");
    pushExp(0, K_BUSY, 1, 64'h0, "rstPreBusy7");
    pushExp(0, K_OK, 0, 64'h1, "rstPreRsvOk");
    applyStimulus(0, 0, 0, 0, 0, 5, 7);
    pushExp(0, K_DAT, 0, 64'hDEADBEEF, "rstPreStored");
    pushExp(0, K_BUSY, 1, 64'h1, "rstPreBusySet");
    pushExp(0, K_CNT, 0, 64'h1, "rstPreCnt");
    nextCycle();
    aRReg = {5'd7, 5'd5};
    rst = 1'b1;
    pushExp(0, K_DAT, 0, 64'h0, "rstMidDat");
    pushExp(0, K_BUSY, 1, 64'h0, "rstMidBusy");
    pushExp(0, K_CNT, 0, 64'h0, "rstMidCnt");
    nextCycle();
    rst = 1'b0;
    pushExp(0, K_DAT, 0, 64'h0, "rstPostDat5");
    pushExp(0, K_BUSY, 1, 64'h0, "rstPostBusy7");
    pushExp(0, K_CNT, 0, 64'h0, "rstPostCnt");

    // Fill r1..r31 with i*3+1, then read back in pairs
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1, 5'(i), 32'(i*3+1), 0, 0, 5'(i), 0);
      if (i == 31) pushExp(0, K_DAT, 0, 64'd94, "fillBypass31");
    end
    for (int i = 1; i < 32; i += 2) begin
      applyStimulus(0, 0, 0, 0, 0, 5'(i), 5'((i+1) % 32));
      pushExp(0, K_DAT, 0, 64'(i*3+1), "fillRead0");
      pushExp(0, K_DAT, 1, (i == 31) ? 64'h0 : 64'((i+1)*3+1), "fillRead1");
    end
    applyStimulus(1, 0, 32'h55, 0, 0, 0, 0);
    pushExp(0, K_DAT, 0, 64'h0, "zeroBypass");
    applyStimulus(0, 0, 0, 0, 0, 0, 3);
    pushExp(0, K_DAT, 0, 64'h0, "zeroStored");
    pushExp(0, K_DAT, 1, 64'd10, "r3Kept");

    // Same-cycle bypass, duplicated on both ports
    applyStimulus(1, 9, 32'h10, 0, 0, 9, 9);
    applyStimulus(1, 9, 32'h77, 0, 0, 9, 9);
    pushExp(0, K_DAT, 0, 64'h77, "bypassP0");
    pushExp(0, K_DAT, 1, 64'h77, "bypassP1");
    applyStimulus(0, 0, 0, 0, 0, 9, 9);
    pushExp(0, K_DAT, 0, 64'h77, "bypassStored");

    // Reservation stall and same-register write+reserve
    applyStimulus(0, 0, 0, 1, 4, 4, 0);
    pushExp(0, K_OK, 0, 64'h1, "rsv4Ok");
    applyStimulus(0, 0, 0, 1, 4, 4, 0);
    pushExp(0, K_OK, 0, 64'h0, "rsv4Stall");
    pushExp(0, K_CNT, 0, 64'h1, "rsv4Cnt");
    applyStimulus(1, 4, 32'h44, 1, 4, 4, 0);
    pushExp(0, K_OK, 0, 64'h1, "rsv4WbOk");
    pushExp(0, K_BUSY, 0, 64'h0, "rsv4WbReady");
    applyStimulus(0, 0, 0, 0, 0, 4, 0);
    pushExp(0, K_DAT, 0, 64'h44, "rsv4Data");
    pushExp(0, K_BUSY, 0, 64'h1, "rsv4StillBusy");
    pushExp(0, K_CNT, 0, 64'h1, "rsv4CntNet");

    // Writeback makes a busy operand ready in the same cycle
    applyStimulus(0, 0, 0, 1, 12, 12, 0);
    pushExp(0, K_OK, 0, 64'h1, "rsv12Ok");
    applyStimulus(1, 12, 32'hA5, 0, 0, 12, 0);
    pushExp(0, K_BUSY, 0, 64'h0, "wb12Ready");
    pushExp(0, K_DAT, 0, 64'hA5, "wb12Bypass");
    pushExp(0, K_CNT, 0, 64'h2, "wb12CntPre");
    applyStimulus(0, 0, 0, 0, 0, 12, 0);
    pushExp(0, K_DAT, 0, 64'hA5, "wb12Stored");
    pushExp(0, K_CNT, 0, 64'h1, "wb12CntPost");

    // Reserving the zero register is accepted but sets nothing
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    pushExp(0, K_OK, 0, 64'h1, "rsv0Ok");
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    pushExp(0, K_BUSY, 0, 64'h0, "rsv0NotBusy");
    pushExp(0, K_CNT, 0, 64'h1, "rsv0Cnt");

    // Wide instance: r0 is ordinary, full reservation of all 16 registers
    applyStimulusB(1, 0, 64'h0123456789ABCDEF, 0, 0, 0, 0, 0);
    for (int p = 0; p < 3; p++) pushExp(1, K_DAT, p, 64'h0123456789ABCDEF, "bBypass");
    applyStimulusB(0, 0, 0, 0, 0, 0, 0, 0);
    for (int p = 0; p < 3; p++) pushExp(1, K_DAT, p, 64'h0123456789ABCDEF, "bStored");
    pushExp(1, K_CNT, 0, 64'h0, "bCntZero");
    for (int i = 0; i < 16; i++) begin
      applyStimulusB(0, 0, 0, 1, 4'(i), 0, 0, 0);
      pushExp(1, K_OK, 0, 64'h1, "bRsvOk");
      pushExp(1, K_CNT, 0, 64'(i), "bRsvCnt");
    end
    applyStimulusB(0, 0, 0, 0, 0, 0, 3, 0);
    pushExp(1, K_CNT, 0, 64'd16, "bCntFull");
    pushExp(1, K_BUSY, 0, 64'h1, "bR0Busy");
    applyStimulusB(0, 0, 0, 1, 3, 0, 3, 0);
    pushExp(1, K_OK, 0, 64'h0, "bRsv3Stall");
    applyStimulusB(1, 3, 64'h5, 0, 0, 0, 3, 0);
    pushExp(1, K_BUSY, 1, 64'h0, "bWb3Ready");
    pushExp(1, K_CNT, 0, 64'd16, "bWb3CntPre");
    applyStimulusB(0, 0, 0, 0, 0, 0, 3, 0);
    pushExp(1, K_CNT, 0, 64'd15, "bWb3CntPost");
    pushExp(1, K_BUSY, 1, 64'h0, "bR3Free");
    pushExp(1, K_DAT, 1, 64'h5, "bR3Data");

    nextCycle();
    begin
      int waitCycles;
      waitCycles = 0;
      while (expQ.size() > 0 && waitCycles < 10) begin
        @(posedge clk);
        waitCycles++;
      end
      if (expQ.size() > 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL drain: got %0d pending, want 0", expQ.size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
